// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared definitions for the fetch stage: FSM state encodings
//               and the default program counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int c_PC_W_DEFAULT = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_FETCH_HI = 2'd0;
    localparam state_t c_FETCH_LO = 2'd1;
    localparam state_t c_ISSUE    = 2'd2;
    localparam state_t c_HALT     = 2'd3;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Memory, instruction-register and execute-stage signals of
//               the fetch stage, grouped with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
import fetch_unit_pkg::*;

interface fetch_unit_if #(
    parameter int PC_W = c_PC_W_DEFAULT
);
    logic [PC_W:0]   mem_addr;
    logic            mem_req;
    logic            mem_ack;
    logic [3:0]      mem_data;
    logic [3:0]      ir_d;
    logic            ir_hi_en;
    logic            ir_lo_en;
    logic            instr_valid;
    logic            exec_ready;
    logic            branch_take;
    logic [PC_W-1:0] branch_addr;
    logic            halt;
    logic [PC_W-1:0] pc_out;
    logic            halted;

    // master = the fetch unit itself
    modport master (
        output mem_addr, mem_req, ir_d, ir_hi_en, ir_lo_en,
               instr_valid, pc_out, halted,
        input  mem_ack, mem_data, exec_ready, branch_take, branch_addr, halt
    );

    modport slave (
        input  mem_addr, mem_req, ir_d, ir_hi_en, ir_lo_en,
               instr_valid, pc_out, halted,
        output mem_ack, mem_data, exec_ready, branch_take, branch_addr, halt
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pc_counter
// Description : Program counter register with synchronous reset, branch load
//               and increment; load wins over increment, increment wraps.
// Revision    : 1.0 - initial release
// ============================================================================
import fetch_unit_pkg::*;

module fetch_unit_pc_counter #(
    parameter int PC_W = c_PC_W_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            res,
    input  wire logic            i_load,
    input  wire logic [PC_W-1:0] i_load_val,
    input  wire logic            i_inc,
    output logic      [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (res) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule : fetch_unit_pc_counter
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Fetches 8-bit instructions as two nibble reads into the IR
//               halves and hands them to execute over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int PC_W = c_PC_W_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     res,
    fetch_unit_if.master  bus
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_handshake;
    logic            w_pc_load;
    logic            w_pc_inc;
    logic [PC_W-1:0] w_pc;

    assign w_handshake = (r_state == c_ISSUE) && bus.exec_ready;
    // halt freezes the pc; branch target beats sequential increment
    assign w_pc_load   = w_handshake && !bus.halt && bus.branch_take;
    assign w_pc_inc    = w_handshake && !bus.halt && !bus.branch_take;

    fetch_unit_pc_counter #(
        .PC_W       (PC_W)
    ) u_pc_counter (
        .clk        (clk),
        .res        (res),
        .i_load     (w_pc_load),
        .i_load_val (bus.branch_addr),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= c_FETCH_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_FETCH_HI: if (bus.mem_ack) w_state_next = c_FETCH_LO;
            c_FETCH_LO: if (bus.mem_ack) w_state_next = c_ISSUE;
            c_ISSUE: begin
                if (w_handshake) begin
                    w_state_next = bus.halt ? c_HALT : c_FETCH_HI;
                end
            end
            default:    w_state_next = c_HALT;
        endcase
    end

    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_addr    = {w_pc, 1'b0};
        bus.ir_hi_en    = 1'b0;
        bus.ir_lo_en    = 1'b0;
        bus.instr_valid = 1'b0;
        bus.halted      = 1'b0;
        case (r_state)
            c_FETCH_HI: begin
                bus.mem_req  = 1'b1;
                bus.ir_hi_en = bus.mem_ack && !res;
            end
            c_FETCH_LO: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {w_pc, 1'b1};
                bus.ir_lo_en = bus.mem_ack && !res;
            end
            c_ISSUE:    bus.instr_valid = 1'b1;
            default:    bus.halted      = 1'b1;
        endcase
    end

    assign bus.ir_d   = bus.mem_data;
    assign bus.pc_out = w_pc;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a local
//               two-nibble IR fed from ir_d and the load enables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic res;
    int   vectors;
    int   miscompares;
    logic [7:0] ir;

    fetch_unit_if #(.PC_W(8)) bus ();

    fetch_unit #(.PC_W(8)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bus.ir_hi_en) ir[7:4] <= bus.ir_d;
        if (bus.ir_lo_en) ir[3:0] <= bus.ir_d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait-state fetch of both nibbles, landing in ISSUE.
    task automatic fetch_fast(input logic [3:0] hi, input logic [3:0] lo);
        bus.exec_ready = 1'b0;
        bus.mem_ack    = 1'b1;
        bus.mem_data   = hi;
        step();
        bus.mem_data   = lo;
        step();
    endtask

    task automatic handshake(input logic hlt, input logic br, input logic [7:0] addr);
        bus.halt        = hlt;
        bus.branch_take = br;
        bus.branch_addr = addr;
        bus.exec_ready  = 1'b1;
        step();
        bus.exec_ready  = 1'b0;
        bus.halt        = 1'b0;
        bus.branch_take = 1'b0;
        bus.branch_addr = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors         = 0;
        miscompares     = 0;
        ir              = 8'h00;
        res             = 1'b1;
        bus.mem_ack     = 1'b0;
        bus.mem_data    = 4'h0;
        bus.exec_ready  = 1'b0;
        bus.branch_take = 1'b0;
        bus.branch_addr = 8'h00;
        bus.halt        = 1'b0;

        step();
        bus.mem_ack = 1'b1;
        chk("rst_hi_en_gated", 16'(bus.ir_hi_en), 16'h0);
        step();
        res         = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        chk("rst_mem_req",     16'(bus.mem_req),     16'h1);
        chk("rst_mem_addr",    16'(bus.mem_addr),    16'h000);
        chk("rst_instr_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_halted",      16'(bus.halted),      16'h0);
        chk("rst_pc_out",      16'(bus.pc_out),      16'h00);

        // zero-wait fetch of A5
        bus.mem_ack  = 1'b1;
        bus.mem_data = 4'hA;
        #1;
        chk("f1_hi_en",  16'(bus.ir_hi_en), 16'h1);
        chk("f1_lo_en0", 16'(bus.ir_lo_en), 16'h0);
        chk("f1_ir_d",   16'(bus.ir_d),     16'hA);
        step();
        bus.mem_data = 4'h5;
        #1;
        chk("f1_addr_lo", 16'(bus.mem_addr), 16'h001);
        chk("f1_lo_en",   16'(bus.ir_lo_en), 16'h1);
        chk("f1_hi_en0",  16'(bus.ir_hi_en), 16'h0);
        step();
        chk("f1_valid",   16'(bus.instr_valid), 16'h1);
        chk("f1_req0",    16'(bus.mem_req),     16'h0);
        chk("f1_en_iss",  16'({bus.ir_hi_en, bus.ir_lo_en}), 16'h0);
        chk("f1_ir",      16'(ir),              16'h00A5);
        handshake(1'b0, 1'b0, 8'h00);
        chk("f1_pc_inc",  16'(bus.pc_out),      16'h01);
        chk("f1_next",    16'(bus.mem_addr),    16'h002);
        chk("f1_valid0",  16'(bus.instr_valid), 16'h0);

        // three wait states per nibble
        bus.mem_ack  = 1'b0;
        bus.mem_data = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_hi_req",  16'(bus.mem_req),  16'h1);
            chk("ws_hi_addr", 16'(bus.mem_addr), 16'h002);
            chk("ws_hi_en0",  16'(bus.ir_hi_en), 16'h0);
            step();
        end
        bus.mem_ack = 1'b1;
        #1;
        chk("ws_hi_en", 16'(bus.ir_hi_en), 16'h1);
        step();
        bus.mem_ack  = 1'b0;
        bus.mem_data = 4'hC;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_lo_req",  16'(bus.mem_req),  16'h1);
            chk("ws_lo_addr", 16'(bus.mem_addr), 16'h003);
            chk("ws_lo_en0",  16'(bus.ir_lo_en), 16'h0);
            step();
        end
        bus.mem_ack = 1'b1;
        #1;
        chk("ws_lo_en", 16'(bus.ir_lo_en), 16'h1);
        step();
        chk("ws_ir", 16'(ir), 16'h003C);

        // execute stall with mem_ack still asserted
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", 16'(bus.instr_valid), 16'h1);
            chk("st_en",    16'({bus.ir_hi_en, bus.ir_lo_en}), 16'h0);
            chk("st_pc",    16'(bus.pc_out), 16'h01);
            step();
        end
        handshake(1'b0, 1'b0, 8'hEE);
        chk("st_pc_inc", 16'(bus.pc_out), 16'h02);

        // branch, then halt+branch together
        fetch_fast(4'h1, 4'h2);
        handshake(1'b0, 1'b1, 8'h3C);
        chk("br_addr",  16'(bus.mem_addr), 16'h078);
        chk("br_pc",    16'(bus.pc_out),   16'h3C);
        fetch_fast(4'h7, 4'h8);
        chk("br_ir",    16'(ir),           16'h0078);
        handshake(1'b1, 1'b1, 8'h11);
        chk("hl_halted", 16'(bus.halted),      16'h1);
        chk("hl_req",    16'(bus.mem_req),     16'h0);
        chk("hl_valid",  16'(bus.instr_valid), 16'h0);
        chk("hl_pc",     16'(bus.pc_out),      16'h3C);
        bus.exec_ready = 1'b1;
        bus.mem_ack    = 1'b1;
        step();
        step();
        chk("hl_stay",    16'(bus.halted), 16'h1);
        chk("hl_en",      16'({bus.ir_hi_en, bus.ir_lo_en}), 16'h0);
        bus.exec_ready = 1'b0;

        // pc wrap
        res = 1'b1;
        step();
        res = 1'b0;
        #1;
        chk("rs2_addr", 16'(bus.mem_addr), 16'h000);
        fetch_fast(4'h0, 4'h0);
        handshake(1'b0, 1'b1, 8'hFF);
        chk("wr_addr_ff", 16'(bus.mem_addr), 16'h1FE);
        fetch_fast(4'hF, 4'hE);
        handshake(1'b0, 1'b0, 8'h00);
        chk("wr_addr", 16'(bus.mem_addr), 16'h000);
        chk("wr_pc",   16'(bus.pc_out),   16'h00);

        // reset during FETCH_LO
        fetch_fast(4'h9, 4'h6);
        handshake(1'b0, 1'b0, 8'h00);
        bus.mem_ack  = 1'b1;
        bus.mem_data = 4'hB;
        step();
        chk("rm_addr_lo", 16'(bus.mem_addr), 16'h003);
        bus.mem_data = 4'hD;
        res = 1'b1;
        #1;
        chk("rm_lo_en0", 16'(bus.ir_lo_en), 16'h0);
        step();
        res         = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        chk("rm_ir",   16'(ir),           16'h00B6);
        chk("rm_addr", 16'(bus.mem_addr), 16'h000);
        chk("rm_pc",   16'(bus.pc_out),   16'h00);
        chk("rm_req",  16'(bus.mem_req),  16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
